// File: rtl/clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_switch_ctrl
//
// Round-robin arbitrating controller for a glitch-free two-source clock mux.
// Requesters ask for a clock source. The winner's target is compared with the
// current mux select. If a change is needed, sel_en toggles and is held for
// SETTLE_CYCLES before the winner is acknowledged. The block runs on an
// always-on system clock and never on either muxed clock.
//
// Optional feature macro: CLKSW_HOLDOFF_EN
//   When it is defined, a DONE that followed a real toggle enters HOLD for
//   HOLDOFF cycles, with busy held high. This bounds the switch rate.
//   When it is undefined, HOLD does not exist and DONE always returns to IDLE.
//
// Parameters:
//   NREQ          number of requesters (>= 2)
//   SETTLE_CYCLES clk cycles sel_en is stable before ack (>= 1)
//   HOLDOFF       idle cycles after a real switch (>= 1, macro build only)
//
// Ports:
//   clk      in   always-on controller clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [NREQ] per-requester request level
//   req_sel  in   [NREQ] per-requester target source (1 = clka, 0 = clkb)
//   ack      out  [NREQ] one-hot, one-cycle completion pulse
//   sel_en   out  registered mux select (drives mux en)
//   busy     out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int HOLDOFF       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_sel,
    output logic [NREQ-1:0] ack,
    output logic            sel_en,
    output logic            busy
);

    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > HOLDOFF) ? SETTLE_CYCLES : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_DONE   = 2'd2
`ifdef CLKSW_HOLDOFF_EN
        , ST_HOLD = 2'd3
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   win_reg, win_next;
    logic            sel_en_reg, sel_en_next;
    logic [NREQ-1:0] ack_reg, ack_next;
    logic [NREQ-1:0] served_reg;
    logic [NREQ-1:0] req_q, req_sel_q;
`ifdef CLKSW_HOLDOFF_EN
    logic            toggled_reg, toggled_next;
`endif

    // Arbitration signals
    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand_idx;

    // Round robin: scan upward from the index after the pointer, wrapping.
    // The pointer's own index is checked last.
    always_comb begin
        eligible  = req_q & ~served_reg;
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = PW'((int'(ptr_reg) + k) % NREQ);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ptr_next    = ptr_reg;
        win_next    = win_reg;
        sel_en_next = sel_en_reg;
        ack_next    = '0;
`ifdef CLKSW_HOLDOFF_EN
        toggled_next = toggled_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    win_next = win_idx;
                    ptr_next = win_idx;
                    if (req_sel_q[win_idx] == sel_en_reg) begin
                        // Already on the requested source: acknowledge at once.
                        state_next = ST_DONE;
                        ack_next[win_idx] = 1'b1;
`ifdef CLKSW_HOLDOFF_EN
                        toggled_next = 1'b0;
`endif
                    end else begin
                        sel_en_next = ~sel_en_reg;
                        cnt_next    = CW'(SETTLE_CYCLES - 1);
                        state_next  = ST_SWITCH;
`ifdef CLKSW_HOLDOFF_EN
                        toggled_next = 1'b1;
`endif
                    end
                end
            end
            ST_SWITCH: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                    ack_next[win_reg] = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_DONE: begin
`ifdef CLKSW_HOLDOFF_EN
                if (toggled_reg) begin
                    cnt_next   = CW'(HOLDOFF - 1);
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
`ifdef CLKSW_HOLDOFF_EN
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // The ack is registered so it is high in exactly the DONE cycle.
    // served latches on ack and drops in any cycle the request is low, so a
    // held request is granted only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            ptr_reg    <= PTR_RST;
            win_reg    <= '0;
            sel_en_reg <= 1'b0;
            ack_reg    <= '0;
            served_reg <= '0;
            req_q      <= '0;
            req_sel_q  <= '0;
`ifdef CLKSW_HOLDOFF_EN
            toggled_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            win_reg    <= win_next;
            sel_en_reg <= sel_en_next;
            ack_reg    <= ack_next;
            served_reg <= (served_reg | ack_reg) & req_q;
            req_q      <= req;
            req_sel_q  <= req_sel;
`ifdef CLKSW_HOLDOFF_EN
            toggled_reg <= toggled_next;
`endif
        end
    end

    assign ack    = ack_reg;
    assign sel_en = sel_en_reg;
    assign busy   = (state_reg != ST_IDLE);

endmodule
